mac_rr_scheduler: RTL and testbench
===================================

# mac_rr_scheduler

Shares one pipelined multiply-accumulate datapath (data_out = a*b + c) among NUM_REQ independent requesters. Per-requester valid/ready handshake, round-robin grant of at most one operation per cycle, two-stage pipelined MAC, and a tagged response port with backpressure. Sits between the requesting blocks and the downstream result consumer.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, operand width of a, b, c
- ID_WIDTH, $clog2(NUM_REQ), width of response tag
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  bit i: requester i presents an operation
- req_ready  out  NUM_REQ  bit i: requester i's operation is accepted this cycle (one-hot or zero)
- req_a  in  NUM_REQ*DATA_WIDTH  operand a, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand b, same packing
- req_c  in  NUM_REQ*DATA_WIDTH  addend c, same packing
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  ID_WIDTH  index of requester that issued the operation
- rsp_data  out  2*DATA_WIDTH  a*b + c
- busy  out  1  any pipeline stage holds a valid operation

## Operation
- Transfer on requester i when req_valid[i] && req_ready[i] in the same cycle; requester holds valid and operands stable until accepted.
- advance = !rsp_valid || rsp_ready. When advance = 0: req_ready = 0, both pipeline stages hold.
- Arbitration (combinational, when advance = 1): search starts at (last_grant + 1) mod NUM_REQ, increasing index with wrap; first requester with req_valid set gets req_ready. No request → req_ready = 0, a bubble enters stage 1.
- last_grant updates to the granted index only on a transfer; reset value NUM_REQ-1, so requester 0 has top priority after reset.
- Stage 1 (on advance): registers product a*b (2*DATA_WIDTH bits), c, id, valid.
- Stage 2 / output register (on advance): rsp_data = product + zero-extended c, rsp_id, rsp_valid = stage-1 valid.
- Arithmetic unsigned. 2*DATA_WIDTH bits never overflow: max (2^DW-1)^2 + (2^DW-1) = 2^2DW - 2^DW.
- Bubbles are not collapsed; a global stall freezes bubbles in place.
- busy = stage-1 valid || rsp_valid.
- Reset (asynchronous, any time, including mid-operation): stage valids, rsp_valid, rsp_id, rsp_data, busy cleared to 0; last_grant = NUM_REQ-1; in-flight operations are discarded, never delivered. req_ready = 0 while reset is high.

## Timing
- Accept in cycle n → rsp_valid, rsp_id, rsp_data visible in cycle n+2 when no stall. Each stall cycle adds one cycle.
- Throughput one operation per cycle while rsp_ready = 1.
- rsp_* stable while rsp_valid && !rsp_ready.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready; no combinational path from req_a/b/c to any output.
- Simultaneous response drain and new accept in the same cycle is legal when rsp_ready = 1.
- Reset values of all outputs: 0.

## Test plan
- Reset then single op: req_valid = 0001, a=3, b=5, c=7 accepted cycle n → req_ready = 0001 in n; rsp_valid = 1, rsp_id = 0, rsp_data = 22 in n+2; busy = 0 in n+3.
- Width corner: DATA_WIDTH = 8, a=b=c=255 → rsp_data = 65280 (0xFF00), no wrap.
- Full contention: req_valid = 1111 held, rsp_ready = 1 → grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence 0,1,2,3,0,1 starting 2 cycles later, no gaps.
- Sparse round-robin: last grant = 1, req_valid = 1010 → grant 3 then 1 then 3; requester 0/2 never granted.
- Backpressure: pipeline full, rsp_ready = 0 for 3 cycles → req_ready = 0, rsp_* unchanged for 3 cycles; on rsp_ready = 1 both queued results emerge in order, none lost or duplicated.
- Reset mid-flight: 2 ops in pipeline, pulse reset between edges → rsp_valid and busy drop to 0 immediately, no stale response after release; next accept with req_valid = 1111 grants requester 0.

Source files
------------

// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin shared two-stage multiply-accumulate pipeline with tagged responses
module mac_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic                          busy
);
    localparam int PW = 2 * DATA_WIDTH;
    logic                  advance;
    logic                  gnt_any;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [ID_WIDTH-1:0]   cand;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] sel_c;
    logic                  s1_valid;
    logic [PW-1:0]         s1_prod;
    logic [DATA_WIDTH-1:0] s1_c;
    logic [ID_WIDTH-1:0]   s1_id;
    assign advance   = !rsp_valid || rsp_ready;
    assign busy      = s1_valid || rsp_valid;
    assign sel_a     = req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b     = req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_c     = req_c[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready = (advance && gnt_any && !reset) ? NUM_REQ'(1) << gnt_idx : '0;
    // Round-robin search from last_grant+1; the nearest candidate is visited last so it wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end
    // Multiply stage, accumulate/output stage and grant pointer, all frozen together on a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_prod    <= '0;
            s1_c       <= '0;
            s1_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else if (advance) begin
            s1_valid  <= gnt_any;
            s1_prod   <= PW'(sel_a) * PW'(sel_b);
            s1_c      <= sel_c;
            s1_id     <= gnt_idx;
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
            rsp_data  <= s1_prod + PW'(s1_c);
            if (gnt_any) last_grant <= gnt_idx;
        end
    end
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler: scoreboard bench for the round-robin shared MAC pipeline
module tb_mac_rr_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rsp_ready = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N*DW-1:0] req_c = '0;
    logic            rsp_valid;
    logic            busy;
    logic [IW-1:0]   rsp_id;
    logic [2*DW-1:0] rsp_data;
    int pass_cnt = 0;
    int total_cnt = 0;
    int oa[N];
    int ob[N];
    int oc[N];
    typedef struct {int id; int data;} exp_t;
    exp_t sb[$];
    int m_last = N - 1;

    mac_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference arbiter and scoreboard: predicts grants, queues expected results, checks responses
    always @(negedge clk) begin : mon
        int g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        if (!reset) begin
            g = -1;
            exp_rdy = '0;
            if (!rsp_valid || rsp_ready)
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) exp_rdy[g] = 1'b1;
            total_cnt++;
            if (req_ready !== exp_rdy) $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
            else pass_cnt++;
            if (rsp_valid && rsp_ready) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL unexpected_rsp: id=%0d data=%0d with empty scoreboard", rsp_id, rsp_data);
                else begin
                    e = sb.pop_front();
                    if (rsp_id !== IW'(e.id) || rsp_data !== 16'(e.data))
                        $display("FAIL rsp: id=%0d data=%0d expected id=%0d data=%0d", rsp_id, rsp_data, e.id, e.data);
                    else pass_cnt++;
                end
            end
            if (g >= 0) begin
                e.id = g;
                e.data = oa[g] * ob[g] + oc[g];
                sb.push_back(e);
                m_last = g;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        oa[i] = a;
        ob[i] = b;
        oc[i] = c;
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
        req_c[i*DW +: DW] = DW'(c);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        sb.delete();
        m_last = N - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        #3;
        total_cnt++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'd0)
            $display("FAIL reset_outputs: ready=%b valid=%b busy=%b id=%0d data=%0d expected all 0", req_ready, rsp_valid, busy, rsp_id, rsp_data);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_held: ready=%b valid=%b busy=%b expected 0", req_ready, rsp_valid, busy);
        else pass_cnt++;
        req_valid = '0;
        reset = 1'b0;
        sb.delete();
        m_last = N - 1;
    endtask

    task automatic test_single();
        step();
        set_op(0, 3, 5, 7);
        req_valid = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready: %b expected 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single_n1: valid=%b busy=%b expected 0 1", rsp_valid, busy);
        else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd22)
            $display("FAIL single_n2: valid=%b id=%0d data=%0d expected 1 0 22", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL single_n3: busy=%b valid=%b expected 0 0", busy, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_width();
        set_op(0, 255, 255, 255);
        req_valid = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL width_ready: %b expected 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        step();
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF00) $display("FAIL width_data: valid=%b data=%0d expected 1 65280", rsp_valid, rsp_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_contention();
        logic [N-1:0] e_r;
        pulse_reset();
        for (int i = 0; i < N; i++) set_op(i, (i + 1) * 10, i + 2, 3 * i);
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 6) begin
                e_r = '0;
                e_r[k % N] = 1'b1;
                total_cnt++;
                if (req_ready !== e_r) $display("FAIL contention_grant%0d: %b expected %b", k, req_ready, e_r);
                else pass_cnt++;
            end
            if (k >= 2) begin
                total_cnt++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'((k - 2) % N))
                    $display("FAIL contention_rsp%0d: valid=%b id=%0d expected 1 %0d", k, rsp_valid, rsp_id, (k - 2) % N);
                else pass_cnt++;
            end
            step();
        end
        step();
    endtask

    task automatic test_sparse();
        logic [N-1:0] e_r;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b1010;
            #1;
            e_r = (k == 1) ? 4'b0010 : 4'b1000;
            total_cnt++;
            if (req_ready !== e_r) $display("FAIL sparse_grant%0d: %b expected %b", k, req_ready, e_r);
            else pass_cnt++;
            step();
        end
        req_valid = '0;
        step();
        step();
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1;
        set_op(0, 1, 2, 3);
        set_op(1, 4, 5, 6);
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            total_cnt++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd5 || busy !== 1'b1)
                $display("FAIL stall%0d: ready=%b valid=%b id=%0d data=%0d busy=%b expected 0000 1 0 5 1", j, req_ready, rsp_valid, rsp_id, rsp_data, busy);
            else pass_cnt++;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd5)
            $display("FAIL release_first: valid=%b id=%0d data=%0d expected 1 0 5", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd26)
            $display("FAIL release_second: valid=%b id=%0d data=%0d expected 1 1 26", rsp_valid, rsp_id, rsp_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL release_empty: valid=%b expected 0", rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        set_op(2, 7, 7, 7);
        set_op(3, 9, 9, 9);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midflight_loaded: valid=%b busy=%b expected 1 1", rsp_valid, busy);
        else pass_cnt++;
        req_valid = 4'b1111;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL midflight_reset: valid=%b busy=%b ready=%b expected 0 0 0000", rsp_valid, busy, req_ready);
        else pass_cnt++;
        req_valid = '0;
        reset = 1'b0;
        sb.delete();
        m_last = N - 1;
        for (int j = 0; j < 3; j++) begin
            step();
            total_cnt++;
            if (rsp_valid !== 1'b0) $display("FAIL stale_rsp%0d: valid=%b expected 0", j, rsp_valid);
            else pass_cnt++;
        end
        req_valid = 4'b1111;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL post_reset_grant: %b expected 0001", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_width();
        test_contention();
        test_sparse();
        test_backpressure();
        test_reset_midflight();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
